// File: rtl/adder_chunk_seq_pkg.sv
// Shared types and elaboration helpers for the chunked sequential adder.
//   state_t      : IDLE (accepting), RUN (one chunk per cycle), DONE (result held)
//   calc_nchunk  : number of chunks an operand is split into
//   calc_cnt_w   : width of the chunk counter (never below one bit)
package adder_chunk_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nchunk(input int data_w, input int chunk_w);
    return data_w / chunk_w;
  endfunction

  function automatic int calc_cnt_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/adder_chunk_seq_adder.sv
// Carry-lookahead adder, combinational.
//   a, b  : WIDTH-bit operands
//   cin   : carry into bit 0
//   sum   : WIDTH-bit result
//   cout  : carry out of bit WIDTH-1
// Every carry is expanded from generate/propagate terms directly, so no carry
// depends on another carry signal.
module adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
  // NOTE: every variable assigned in always_comb gets a value on every path
  // before it is read; a missed default would infer a latch.
  always_comb begin
    logic carry_acc;
    logic prop_run;
    carry     = '0;
    carry_acc = 1'b0;
    prop_run  = 1'b0;
    carry[0]  = cin;
    for (int i = 0; i < WIDTH; i++) begin
      carry_acc = gen[i];
      prop_run  = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        carry_acc = carry_acc | (prop_run & gen[j]);
        prop_run  = prop_run & prop[j];
      end
      carry[i+1] = carry_acc | (prop_run & cin);
    end
  end

  assign sum  = prop ^ carry[WIDTH-1:0];
  assign cout = carry[WIDTH];

endmodule

// File: rtl/adder_chunk_seq.sv
// Multi-cycle wide adder/subtractor. Operands are captured once, then added
// CHUNK_W bits per cycle (LSB chunk first) through a single CLA, with the
// chunk carry registered between cycles.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b, cin, sub        : operands; sub=1 adds ~b (use cin=1 for a-b)
//   out_valid / out_ready : result handshake
//   sum, cout, overflow   : result, unsigned carry out, signed overflow
// Latency from accept edge to out_valid is DATA_W/CHUNK_W cycles.
module adder_chunk_seq
  import adder_chunk_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CHUNK_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              overflow
);

  localparam int NCHUNK = calc_nchunk(DATA_W, CHUNK_W);
  localparam int CNT_W  = calc_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  if (DATA_W % CHUNK_W != 0) begin : g_bad_width
    $error("adder_chunk_seq: DATA_W must be a multiple of CHUNK_W");
  end

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              carry_q;
  logic [CNT_W-1:0]  cnt;

  logic [CHUNK_W-1:0] chunk_a;
  logic [CHUNK_W-1:0] chunk_b;
  logic [CHUNK_W-1:0] chunk_sum;
  logic               chunk_cout;

  logic accept;
  logic last_chunk;
  logic release_out;

  assign in_ready    = (state == IDLE);
  assign accept      = in_valid && in_ready;
  assign last_chunk  = (cnt == LAST_CHUNK);
  assign release_out = out_valid && out_ready;

  assign chunk_a = a_q[int'(cnt)*CHUNK_W +: CHUNK_W];
  assign chunk_b = b_q[int'(cnt)*CHUNK_W +: CHUNK_W];

  adder #(.WIDTH(CHUNK_W)) u_adder (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)      state_next = RUN;
      RUN:     if (last_chunk)  state_next = DONE;
      DONE:    if (release_out) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Operand registers are reset too: a reset mid-RUN must leave no stale
  // carry or operand bits for the next operation to pick up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= cin;
            cnt     <= '0;
          end
        end
        RUN: begin
          sum[int'(cnt)*CHUNK_W +: CHUNK_W] <= chunk_sum;
          carry_q <= chunk_cout;
          if (last_chunk) begin
            cout      <= chunk_cout;
            // a^b^sum at the MSB recovers the carry into the MSB.
            overflow  <= a_q[DATA_W-1] ^ b_q[DATA_W-1] ^ chunk_sum[CHUNK_W-1] ^ chunk_cout;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (release_out) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_chunk_seq.sv
// Bench for adder_chunk_seq: directed cases on a 16/4 instance, plus random
// operations with back-pressure on 16/4, 4/4 and 64/8 instances, all checked
// against an arithmetic reference computed here.
module tb_adder_chunk_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- directed instance (16/4) ----------------
  logic        d_rst_n;
  logic        d_in_valid, d_in_ready, d_cin, d_sub;
  logic        d_out_valid, d_out_ready, d_cout, d_ovf;
  logic [15:0] d_a, d_b, d_sum;

  adder_chunk_seq #(.DATA_W(16), .CHUNK_W(4)) u_dut_d (
    .clk(clk), .rst_n(d_rst_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .cin(d_cin), .sub(d_sub),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .sum(d_sum), .cout(d_cout), .overflow(d_ovf)
  );

  task automatic wait_accept_d();
    int n;
    n = 0;
    while (!d_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("accept wait", d_in_ready, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_result_d(input string tag);
    int n;
    n = 0;
    while (!d_out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check({tag, " latency"}, n, 4);
  endtask

  task automatic d_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                      input string tag, input logic [15:0] exp_sum, input logic exp_cout,
                      input logic exp_ovf);
    d_a = a; d_b = b; d_cin = c; d_sub = s; d_in_valid = 1'b1;
    wait_accept_d();
    d_in_valid = 1'b0;
    d_a = 16'hdead; d_b = 16'hbeef; d_cin = ~c; d_sub = ~s;
    wait_result_d(tag);
    check({tag, " sum"}, d_sum, exp_sum);
    check({tag, " cout"}, d_cout, exp_cout);
    check({tag, " ovf"}, d_ovf, exp_ovf);
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    check({tag, " released"}, d_out_valid, 0);
  endtask

  // ---------------- random lanes ----------------
  logic r_rst_n;

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int DW  = (g == 1) ? 4 : (g == 2) ? 64 : 16;
    localparam int CW  = (g == 2) ? 8 : 4;
    localparam int NCH = DW / CW;

    logic          in_valid, in_ready, cin, sub;
    logic          out_valid, out_ready, cout, ovf;
    logic          done = 1'b0;
    logic [DW-1:0] a, b, sum;

    adder_chunk_seq #(.DATA_W(DW), .CHUNK_W(CW)) u_dut (
      .clk(clk), .rst_n(r_rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .overflow(ovf)
    );

    initial begin
      logic [63:0]   r;
      logic [DW-1:0] ea, eb, bb, exp_sum;
      logic [DW:0]   full;
      logic          ecin, esub, exp_ovf;
      string         nm;
      int            n;
      nm = $sformatf("L%0d_%0d", DW, CW);
      in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
      a = '0; b = '0;
      wait (r_rst_n);
      @(posedge clk); #1;
      for (int i = 0; i < 1000; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        r = {$urandom(), $urandom()}; ea = r[DW-1:0];
        r = {$urandom(), $urandom()}; eb = r[DW-1:0];
        ecin = 1'($urandom_range(0, 1));
        esub = 1'($urandom_range(0, 1));
        a = ea; b = eb; cin = ecin; sub = esub; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        check({nm, " accept"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        r = {$urandom(), $urandom()}; a = r[DW-1:0]; b = ~r[DW-1:0];
        cin = ~ecin; sub = ~esub;
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        check({nm, " latency"}, n, NCH);

        bb      = esub ? ~eb : eb;
        full    = {1'b0, ea} + {1'b0, bb} + {{DW{1'b0}}, ecin};
        exp_sum = full[DW-1:0];
        exp_ovf = (ea[DW-1] == bb[DW-1]) && (exp_sum[DW-1] != ea[DW-1]);
        check({nm, " sum"}, 64'(sum), 64'(exp_sum));
        check({nm, " cout"}, cout, full[DW]);
        check({nm, " ovf"}, ovf, exp_ovf);

        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        check({nm, " sum held"}, 64'(sum), 64'(exp_sum));
        check({nm, " in_ready low"}, in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, " released"}, out_valid, 0);
      end
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    d_rst_n = 1'b0; r_rst_n = 1'b0;
    d_in_valid = 1'b0; d_out_ready = 1'b0; d_cin = 1'b0; d_sub = 1'b0;
    d_a = '0; d_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", d_out_valid, 0);
    check("reset sum", d_sum, 0);
    check("reset cout", d_cout, 0);
    check("reset ovf", d_ovf, 0);
    check("reset in_ready", d_in_ready, 1);
    d_rst_n = 1'b1; r_rst_n = 1'b1;
    @(posedge clk); #1;

    d_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "t1", 16'h0000, 1'b1, 1'b0);
    d_op(16'h0005, 16'h0007, 1'b1, 1'b1, "t2a", 16'hFFFE, 1'b0, 1'b0);
    d_op(16'h0007, 16'h0005, 1'b1, 1'b1, "t2b", 16'h0002, 1'b1, 1'b0);
    d_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "t3a", 16'h8000, 1'b0, 1'b1);
    d_op(16'h8000, 16'h0001, 1'b1, 1'b1, "t3b", 16'h7FFF, 1'b1, 1'b1);

    // Back-pressure: a second request held high across DONE.
    d_a = 16'h0003; d_b = 16'h0004; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1;
    wait_accept_d();
    d_a = 16'h0010; d_b = 16'h0020;
    wait_result_d("t4");
    for (int k = 0; k < 5; k++) begin
      check("t4 hold sum", d_sum, 16'h0007);
      check("t4 hold in_ready", d_in_ready, 0);
      @(posedge clk); #1;
    end
    check("t4 still valid", d_out_valid, 1);
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    check("t4 out_valid drop", d_out_valid, 0);
    check("t4 ready after handshake", d_in_ready, 1);
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    check("t4 second accepted", d_in_ready, 0);
    wait_result_d("t4b");
    check("t4 second sum", d_sum, 16'h0030);
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;

    // Reset mid-RUN with a live carry in the chunk chain.
    d_a = 16'hFFFF; d_b = 16'h0001; d_cin = 1'b0; d_sub = 1'b0; d_in_valid = 1'b1;
    wait_accept_d();
    d_in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    d_rst_n = 1'b0;
    #1;
    check("t5 out_valid in reset", d_out_valid, 0);
    check("t5 in_ready in reset", d_in_ready, 1);
    check("t5 sum in reset", d_sum, 0);
    repeat (2) @(posedge clk);
    #1;
    d_rst_n = 1'b1;
    check("t5 in_ready after reset", d_in_ready, 1);
    d_op(16'h0001, 16'h0001, 1'b0, 1'b0, "t5", 16'h0002, 1'b0, 1'b0);

    n = 0;
    while (!(lane[0].done && lane[1].done && lane[2].done) && n < 60000) begin
      @(posedge clk); n++;
    end
    check("random lanes finished", {lane[0].done, lane[1].done, lane[2].done}, 3'b111);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
